// File: rtl/fir_out_checker.sv
// Self-checking consumer for the FIR output stream: compares each valid sample
// against a preloaded expected table within a tolerance and reports the result.
module fir_out_checker #(
  parameter int          WIDTH  = 14,
  parameter int          ADDR_W = 10,
  parameter int unsigned TOL    = 0
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     VIN,
  input  logic signed [WIDTH-1:0]  DIN,
  input  logic                     EXP_WE,
  input  logic        [ADDR_W-1:0] EXP_ADDR,
  input  logic signed [WIDTH-1:0]  EXP_DATA,
  input  logic        [ADDR_W:0]   N_EXP,
  input  logic                     START,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     PASS,
  output logic        [15:0]       ERR_CNT,
  output logic        [ADDR_W-1:0] FIRST_ERR_IDX,
  output logic        [7:0]        OVF_CNT
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [WIDTH:0] TOL_V = (WIDTH+1)'(TOL);

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] exp_mem [2**ADDR_W];

  logic [ADDR_W:0]         n_q;
  logic [ADDR_W:0]         idx;
  logic [ADDR_W:0]         idx_nxt;
  logic [ADDR_W-1:0]       idx_q;
  logic signed [WIDTH-1:0] din_q;
  logic signed [WIDTH-1:0] exp_q;
  logic                    valid_q;
  logic                    last_q;

  logic                    start_ok;
  logic                    draining;
  logic                    accept;
  logic                    ovf_ev;
  logic [WIDTH:0]          diff;
  logic [WIDTH:0]          abs_diff;
  logic                    mismatch;

  // The last sample sits in stage 2 while draining; new VINs then count as overflow.
  assign start_ok = START && (state != ST_RUN);
  assign draining = valid_q && last_q;
  assign accept   = (state == ST_RUN) && VIN && !draining;
  assign ovf_ev   = VIN && !start_ok && ((state == ST_DONE) || draining);
  assign idx_nxt  = idx + 1'b1;

  // Sign-extended subtraction cannot overflow in WIDTH+1 bits.
  assign diff     = {din_q[WIDTH-1], din_q} - {exp_q[WIDTH-1], exp_q};
  assign abs_diff = diff[WIDTH] ? (~diff + 1'b1) : diff;
  assign mismatch = valid_q && (abs_diff > TOL_V);

  // Table has no reset so its contents survive RST_n.
  always_ff @(posedge CLK) begin
    if (EXP_WE && (state != ST_RUN)) begin
      exp_mem[EXP_ADDR] <= EXP_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_nxt = (N_EXP == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (draining) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == ST_RUN);
    DONE = (state == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      n_q           <= '0;
      idx           <= '0;
      idx_q         <= '0;
      din_q         <= '0;
      exp_q         <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      ERR_CNT       <= '0;
      FIRST_ERR_IDX <= '0;
      OVF_CNT       <= '0;
      PASS          <= 1'b0;
    end else if (start_ok) begin
      n_q           <= N_EXP;
      idx           <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      ERR_CNT       <= '0;
      FIRST_ERR_IDX <= '0;
      OVF_CNT       <= '0;
      PASS          <= (N_EXP == '0);
    end else begin
      valid_q <= accept;
      if (accept) begin
        din_q  <= DIN;
        exp_q  <= exp_mem[idx[ADDR_W-1:0]];
        idx_q  <= idx[ADDR_W-1:0];
        last_q <= (idx_nxt == n_q);
        idx    <= idx_nxt;
      end
      if (mismatch) begin
        if (ERR_CNT == '0) begin
          FIRST_ERR_IDX <= idx_q;
        end
        if (ERR_CNT != 16'hFFFF) begin
          ERR_CNT <= ERR_CNT + 16'd1;
        end
      end
      if (ovf_ev && (OVF_CNT != 8'hFF)) begin
        OVF_CNT <= OVF_CNT + 8'd1;
      end
      if (draining) begin
        PASS <= (ERR_CNT == '0) && !mismatch && !ovf_ev;
      end else if (ovf_ev) begin
        PASS <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_checker.sv
// Randomised bench for fir_out_checker: two instances (TOL=0 and TOL=1) share
// stimulus and are checked against a per-run reference model of the expected table.
module tb_fir_out_checker;

  logic                CLK = 1'b0;
  logic                RST_n = 1'b0;
  logic                VIN = 1'b0;
  logic signed [13:0]  DIN = '0;
  logic                EXP_WE = 1'b0;
  logic        [9:0]   EXP_ADDR = '0;
  logic signed [13:0]  EXP_DATA = '0;
  logic        [10:0]  N_EXP = '0;
  logic                START = 1'b0;

  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0, err1;
  logic [9:0]  first0, first1;
  logic [7:0]  ovf0, ovf1;

  int checks = 0;
  int errors = 0;
  int tab_m [1024];
  int stim [$];
  bit arm = 1'b0;
  bit watch_done = 1'b0;

  fir_out_checker #(.WIDTH(14), .ADDR_W(10), .TOL(0)) u_dut0 (
    .CLK(CLK), .RST_n(RST_n), .VIN(VIN), .DIN(DIN), .EXP_WE(EXP_WE),
    .EXP_ADDR(EXP_ADDR), .EXP_DATA(EXP_DATA), .N_EXP(N_EXP), .START(START),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0),
    .FIRST_ERR_IDX(first0), .OVF_CNT(ovf0)
  );

  fir_out_checker #(.WIDTH(14), .ADDR_W(10), .TOL(1)) u_dut1 (
    .CLK(CLK), .RST_n(RST_n), .VIN(VIN), .DIN(DIN), .EXP_WE(EXP_WE),
    .EXP_ADDR(EXP_ADDR), .EXP_DATA(EXP_DATA), .N_EXP(N_EXP), .START(START),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1),
    .FIRST_ERR_IDX(first1), .OVF_CNT(ovf1)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock; also checks DONE stays low on the last-sample edge and rises on the next.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (watch_done) begin
      checkOutput("done_after_last", int'(done0), 1);
      checkOutput("busy_after_last", int'(busy0), 0);
      watch_done = 1'b0;
    end
    if (arm) begin
      checkOutput("done_on_last_edge", int'(done0), 0);
      arm = 1'b0;
      watch_done = 1'b1;
    end
  endtask

  task automatic writeTable(input int addr, input int val);
    EXP_WE   = 1'b1;
    EXP_ADDR = 10'(addr);
    EXP_DATA = 14'(val);
    tick();
    EXP_WE = 1'b0;
    tab_m[addr] = val;
  endtask

  function automatic int absVal(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int expErr(input int n, input int tol);
    int cnt = 0;
    for (int i = 0; i < n && i < stim.size(); i++)
      if (absVal(stim[i] - tab_m[i]) > tol) cnt++;
    return cnt;
  endfunction

  function automatic int expFirst(input int n, input int tol);
    for (int i = 0; i < n && i < stim.size(); i++)
      if (absVal(stim[i] - tab_m[i]) > tol) return i;
    return 0;
  endfunction

  task automatic checkFinal(input string tag, input int n);
    int e0, e1, ovf;
    e0  = expErr(n, 0);
    e1  = expErr(n, 1);
    ovf = (stim.size() > n) ? stim.size() - n : 0;
    if (ovf > 255) ovf = 255;
    checkOutput({tag, "_err_tol0"}, int'(err0), e0);
    if (e0 != 0) checkOutput({tag, "_first_tol0"}, int'(first0), expFirst(n, 0));
    checkOutput({tag, "_ovf_tol0"}, int'(ovf0), ovf);
    checkOutput({tag, "_pass_tol0"}, int'(pass0), int'(e0 == 0 && ovf == 0));
    checkOutput({tag, "_done_tol0"}, int'(done0), 1);
    checkOutput({tag, "_err_tol1"}, int'(err1), e1);
    if (e1 != 0) checkOutput({tag, "_first_tol1"}, int'(first1), expFirst(n, 1));
    checkOutput({tag, "_ovf_tol1"}, int'(ovf1), ovf);
    checkOutput({tag, "_pass_tol1"}, int'(pass1), int'(e1 == 0 && ovf == 0));
    checkOutput({tag, "_busy_tol1"}, int'(busy1), 0);
  endtask

  // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps.
  task automatic applyStimulus(input string tag, input int n, input int gap_mode,
                               input bit start_write, input int sw_val, input bit run_write);
    START = 1'b1;
    N_EXP = 11'(n);
    if (start_write) begin
      EXP_WE   = 1'b1;
      EXP_ADDR = '0;
      EXP_DATA = 14'(sw_val);
      tab_m[0] = sw_val;
    end
    tick();
    START  = 1'b0;
    EXP_WE = 1'b0;
    checkOutput({tag, "_busy_rise"}, int'(busy0), int'(n != 0));
    checkOutput({tag, "_done_start"}, int'(done0), int'(n == 0));
    if (n == 0) checkOutput({tag, "_pass_start"}, int'(pass0), 1);
    for (int i = 0; i < stim.size(); i++) begin
      VIN = 1'b1;
      DIN = 14'(stim[i]);
      if (run_write && i == 0) begin
        EXP_WE   = 1'b1;
        EXP_ADDR = 10'(n - 1);
        EXP_DATA = 14'(tab_m[n-1]) ^ 14'd1;
      end
      if (i == n - 1) arm = 1'b1;
      tick();
      VIN    = 1'b0;
      EXP_WE = 1'b0;
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) tick();
    end
    repeat (3) tick();
    checkFinal(tag, n);
  endtask

  initial begin
    int base [8] = '{0, 100, -100, 8191, -8192, 1, -1, 42};
    int n, v, d, extra;

    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_busy", int'(busy0), 0);
    checkOutput("reset_done", int'(done0), 0);
    checkOutput("reset_pass", int'(pass0), 0);
    checkOutput("reset_err", int'(err0), 0);
    checkOutput("reset_ovf", int'(ovf0), 0);
    @(negedge CLK);
    RST_n = 1'b1;

    VIN = 1'b1;
    DIN = 14'sd5;
    tick();
    VIN = 1'b0;
    tick();
    checkOutput("idle_vin_err", int'(err0), 0);
    checkOutput("idle_vin_ovf", int'(ovf0), 0);
    checkOutput("idle_vin_busy", int'(busy0), 0);

    stim.delete();
    applyStimulus("nexp0", 0, 0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 8; i++) writeTable(i, base[i]);

    stim.delete();
    foreach (base[i]) stim.push_back(base[i]);
    applyStimulus("exact", 8, 0, 1'b0, 0, 1'b0);

    stim[3] = 8190;
    stim[6] = 5;
    applyStimulus("two_err_gapped", 8, 1, 1'b0, 0, 1'b0);

    stim[6] = -1;
    stim[4] = 8191;
    applyStimulus("tol_edge", 8, 0, 1'b0, 0, 1'b0);

    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(base[i]);
    applyStimulus("overflow", 4, 0, 1'b0, 0, 1'b0);
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(base[i]);
    applyStimulus("rerun_clean", 4, 0, 1'b0, 0, 1'b0);

    // Asynchronous reset mid-run with one mismatch already counted.
    START = 1'b1;
    N_EXP = 11'd8;
    tick();
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      VIN = 1'b1;
      DIN = (i == 0) ? 14'sd7 : 14'(base[i]);
      tick();
    end
    VIN = 1'b0;
    checkOutput("prereset_err", int'(err0), 1);
    checkOutput("prereset_busy", int'(busy0), 1);
    #2;
    RST_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", int'(busy0), 0);
    checkOutput("async_rst_err", int'(err0), 0);
    checkOutput("async_rst_first", int'(first0), 0);
    checkOutput("async_rst_done", int'(done0), 0);
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    tick();
    checkOutput("post_rst_busy", int'(busy0), 0);
    stim.delete();
    foreach (base[i]) stim.push_back(base[i]);
    applyStimulus("after_reset", 8, 0, 1'b0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(2, 12);
      for (int i = 0; i < n; i++) writeTable(i, int'($urandom_range(0, 16383)) - 8192);
      stim.delete();
      for (int i = 0; i < n; i++) begin
        d = $urandom_range(0, 4);
        case (d)
          2: v = tab_m[i] + 1;
          3: v = tab_m[i] - 1;
          4: v = int'($urandom_range(0, 16383)) - 8192;
          default: v = tab_m[i];
        endcase
        if (v > 8191 || v < -8192) v = tab_m[i];
        stim.push_back(v);
      end
      extra = $urandom_range(0, 2);
      for (int i = 0; i < extra; i++) stim.push_back(int'($urandom_range(0, 16383)) - 8192);
      if (r == 2) begin
        v = int'($urandom_range(0, 16383)) - 8192;
        stim[0] = v;
        applyStimulus("rand_startwrite", n, $urandom_range(0, 2), 1'b1, v, 1'b0);
      end else begin
        applyStimulus("rand", n, $urandom_range(0, 2), 1'b0, 0, r == 3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
